// File: rtl/hilo_muldiv_if.sv
// Request/result bundle between the execute stage and the HI/LO multiply/divide unit.
interface hilo_muldiv_if #(
    parameter int unsigned WIDTH = 32
) ();
    logic             start_i;
    logic [2:0]       op_i;
    logic [WIDTH-1:0] src0_i;
    logic [WIDTH-1:0] src1_i;
    logic             flush_i;
    logic             busy_o;
    logic             done_o;
    logic             div0_o;
    logic [WIDTH-1:0] hi_o;
    logic [WIDTH-1:0] lo_o;

    modport master (
        output start_i, op_i, src0_i, src1_i, flush_i,
        input  busy_o, done_o, div0_o, hi_o, lo_o
    );

    modport slave (
        input  start_i, op_i, src0_i, src1_i, flush_i,
        output busy_o, done_o, div0_o, hi_o, lo_o
    );
endinterface

// File: rtl/hilo_muldiv.sv
// Iterative radix-2 multiply/divide unit owning the architectural HI/LO registers.
// Signed ops run on magnitudes; signs are reapplied in a single fix-up cycle.
module hilo_muldiv #(
    parameter int unsigned WIDTH = 32
) (
    input logic          clk_i,
    input logic          rst_i,
    hilo_muldiv_if.slave bus
);
    localparam int unsigned CntW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {StIdle, StMul, StDiv, StFix, StDz} state_e;

    state_e             state_q, state_d;
    logic [CntW-1:0]    cnt_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   rem_q, b_q, hi_q, lo_q;
    logic               neg_res_q, neg_rem_q, is_div_q, done_q, div0_q;
    logic               busy;

    // Request decode
    logic             accept, is_md, is_mthi, is_mtlo, is_dv, sgn, div_zero;
    logic [WIDTH-1:0] mag0, mag1;

    always_comb begin
        accept   = bus.start_i && (state_q == StIdle) && !bus.flush_i;
        is_md    = !bus.op_i[2];
        is_mthi  = bus.op_i == 3'b100;
        is_mtlo  = bus.op_i == 3'b101;
        is_dv    = bus.op_i[1];
        sgn      = !bus.op_i[0];
        div_zero = bus.src1_i == '0;
        mag0     = (sgn && bus.src0_i[WIDTH-1]) ? -bus.src0_i : bus.src0_i;
        mag1     = (sgn && bus.src1_i[WIDTH-1]) ? -bus.src1_i : bus.src1_i;
    end

    // Iteration datapath
    logic [WIDTH:0]     mul_sum, div_shift, div_trial;
    logic [2*WIDTH-1:0] mul_next, prod_fix;
    logic [WIDTH-1:0]   div_rem, div_quo, quo_fix, rem_fix;

    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
        mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
        // Restoring step: keep the shifted remainder when the trial subtraction borrows.
        div_shift = {rem_q, acc_q[WIDTH-1]};
        div_trial = div_shift - {1'b0, b_q};
        div_rem   = div_trial[WIDTH] ? div_shift[WIDTH-1:0] : div_trial[WIDTH-1:0];
        div_quo   = {acc_q[WIDTH-2:0], !div_trial[WIDTH]};
        prod_fix  = neg_res_q ? -acc_q : acc_q;
        quo_fix   = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix   = neg_rem_q ? -rem_q : rem_q;
    end

    // FSM: state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        if (bus.flush_i) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    if (accept && is_md) begin
                        if (!is_dv)        state_d = StMul;
                        else if (div_zero) state_d = StDz;
                        else               state_d = StDiv;
                    end
                end
                StMul, StDiv: begin
                    if (cnt_q == CntW'(WIDTH - 1)) state_d = StFix;
                end
                StFix, StDz: state_d = StIdle;
                default:     state_d = StIdle;
            endcase
        end
    end

    // FSM: outputs
    always_comb begin
        busy = state_q != StIdle;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q     <= '0;
            acc_q     <= '0;
            rem_q     <= '0;
            b_q       <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            is_div_q  <= 1'b0;
            done_q    <= 1'b0;
            div0_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            div0_q <= 1'b0;
            if (!bus.flush_i) begin
                case (state_q)
                    StIdle: begin
                        if (accept && is_mthi) hi_q <= bus.src0_i;
                        if (accept && is_mtlo) lo_q <= bus.src0_i;
                        if (accept && is_md) begin
                            // Divide-by-zero parks the raw dividend for HI.
                            acc_q     <= {{WIDTH{1'b0}},
                                          is_dv ? (div_zero ? bus.src0_i : mag0) : mag1};
                            b_q       <= is_dv ? mag1 : mag0;
                            rem_q     <= '0;
                            cnt_q     <= '0;
                            is_div_q  <= is_dv;
                            neg_res_q <= sgn && (bus.src0_i[WIDTH-1] ^ bus.src1_i[WIDTH-1]);
                            neg_rem_q <= sgn && bus.src0_i[WIDTH-1];
                        end
                    end
                    StMul: begin
                        acc_q <= mul_next;
                        cnt_q <= cnt_q + 1'b1;
                    end
                    StDiv: begin
                        acc_q[WIDTH-1:0] <= div_quo;
                        rem_q            <= div_rem;
                        cnt_q            <= cnt_q + 1'b1;
                    end
                    StFix: begin
                        if (is_div_q) begin
                            hi_q <= rem_fix;
                            lo_q <= quo_fix;
                        end else begin
                            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                            lo_q <= prod_fix[WIDTH-1:0];
                        end
                        done_q <= 1'b1;
                    end
                    StDz: begin
                        hi_q   <= acc_q[WIDTH-1:0];
                        lo_q   <= '1;
                        done_q <= 1'b1;
                        div0_q <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.busy_o = busy;
    assign bus.done_o = done_q;
    assign bus.div0_o = div0_q;
    assign bus.hi_o   = hi_q;
    assign bus.lo_o   = lo_q;
endmodule
